// File: rtl/coord_pkg.sv
// Shared coordinate width, grid/budget limits and tracker state encoding.
package coord_pkg;

    localparam int unsigned COORD_W   = 5;
    localparam int unsigned GRID_MAX  = 15;
    localparam int unsigned MAX_MOVES = 31;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StSettle,
        StDone,
        StFail
    } state_e;

endpackage

// File: rtl/in_bounds.sv
// Combinational grid check: ok when both coordinates are within 0..GRID_MAX.
module in_bounds #(
    parameter int unsigned GRID_MAX = coord_pkg::GRID_MAX
) (
    input  logic [coord_pkg::COORD_W-1:0] cx,
    input  logic [coord_pkg::COORD_W-1:0] cy,
    output logic                          ok
);
    import coord_pkg::*;

    // Borrow-wrapped values (e.g. 31 from 0-1) land above GRID_MAX and fail here.
    assign ok = (cx <= COORD_W'(GRID_MAX)) && (cy <= COORD_W'(GRID_MAX));

endmodule

// File: rtl/position_tracker.sv
// Tracks a committed grid position under a move budget; accepts one move per RUN
// cycle, settles one cycle after each move, and flags target reached or budget spent.
module position_tracker #(
    parameter int unsigned GRID_MAX  = coord_pkg::GRID_MAX,
    parameter int unsigned MAX_MOVES = coord_pkg::MAX_MOVES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [coord_pkg::COORD_W-1:0] sx,
    input  logic [coord_pkg::COORD_W-1:0] sy,
    input  logic [coord_pkg::COORD_W-1:0] tx,
    input  logic [coord_pkg::COORD_W-1:0] ty,
    input  logic                          move_valid,
    input  logic [coord_pkg::COORD_W-1:0] fx,
    input  logic [coord_pkg::COORD_W-1:0] fy,
    output logic [coord_pkg::COORD_W-1:0] x,
    output logic [coord_pkg::COORD_W-1:0] y,
    output logic                          move_ready,
    output logic [coord_pkg::COORD_W-1:0] move_count,
    output logic                          oob,
    output logic                          reached,
    output logic                          exhausted
);
    import coord_pkg::*;

    state_e             state_q;
    logic               start_ok;
    logic               move_ok;
    logic               start_at_target;
    logic               move_at_target;
    logic [COORD_W-1:0] count_inc;
    logic               budget_hit;

    in_bounds #(
        .GRID_MAX(GRID_MAX)
    ) u_start_chk (
        .cx(sx),
        .cy(sy),
        .ok(start_ok)
    );

    in_bounds #(
        .GRID_MAX(GRID_MAX)
    ) u_move_chk (
        .cx(fx),
        .cy(fy),
        .ok(move_ok)
    );

    assign start_at_target = (sx == tx) && (sy == ty);
    assign move_at_target  = (fx == tx) && (fy == ty);
    assign count_inc       = move_count + COORD_W'(1);
    assign budget_hit      = (count_inc == COORD_W'(MAX_MOVES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            x          <= '0;
            y          <= '0;
            move_count <= '0;
            move_ready <= 1'b0;
            oob        <= 1'b0;
            reached    <= 1'b0;
            exhausted  <= 1'b0;
        end else begin
            oob <= 1'b0;
            unique case (state_q)
                StIdle, StDone, StFail: begin
                    if (start) begin
                        move_count <= '0;
                        reached    <= 1'b0;
                        exhausted  <= 1'b0;
                        if (!start_ok) begin
                            // Illegal start: position untouched, not a budget failure.
                            state_q    <= StFail;
                            oob        <= 1'b1;
                            move_ready <= 1'b0;
                        end else begin
                            x <= sx;
                            y <= sy;
                            if (start_at_target) begin
                                state_q    <= StDone;
                                reached    <= 1'b1;
                                move_ready <= 1'b0;
                            end else begin
                                state_q    <= StRun;
                                move_ready <= 1'b1;
                            end
                        end
                    end
                end
                StRun: begin
                    if (move_valid) begin
                        move_count <= count_inc;
                        move_ready <= 1'b0;
                        if (move_ok) begin
                            x <= fx;
                            y <= fy;
                        end else begin
                            oob <= 1'b1;
                        end
                        // Reaching the target beats running out of budget on the same move.
                        if (move_ok && move_at_target) begin
                            state_q <= StDone;
                            reached <= 1'b1;
                        end else if (budget_hit) begin
                            state_q   <= StFail;
                            exhausted <= 1'b1;
                        end else begin
                            state_q <= StSettle;
                        end
                    end
                end
                StSettle: begin
                    state_q    <= StRun;
                    move_ready <= 1'b1;
                end
                default: begin
                    state_q    <= StIdle;
                    move_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_position_tracker.sv
// Directed bench: two trackers (budgets 3 and 2) share stimulus, outputs checked per instance.
module tb_position_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [4:0] sx = '0, sy = '0, tx = '0, ty = '0;
    logic       move_valid = 1'b0;
    logic [4:0] fx = '0, fy = '0;

    logic [4:0] x3, y3, cnt3, x2, y2, cnt2;
    logic       rdy3, oob3, rch3, exh3, rdy2, oob2, rch2, exh2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    position_tracker #(.GRID_MAX(15), .MAX_MOVES(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .sx(sx), .sy(sy), .tx(tx), .ty(ty),
        .move_valid(move_valid), .fx(fx), .fy(fy), .x(x3), .y(y3), .move_ready(rdy3),
        .move_count(cnt3), .oob(oob3), .reached(rch3), .exhausted(exh3)
    );

    position_tracker #(.GRID_MAX(15), .MAX_MOVES(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .sx(sx), .sy(sy), .tx(tx), .ty(ty),
        .move_valid(move_valid), .fx(fx), .fy(fy), .x(x2), .y(y2), .move_ready(rdy2),
        .move_count(cnt2), .oob(oob2), .reached(rch2), .exhausted(exh2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [4:0] a, b, c, d);
        start = 1'b1; sx = a; sy = b; tx = c; ty = d;
        step();
        start = 1'b0;
    endtask

    task automatic do_move(input logic [4:0] a, b);
        move_valid = 1'b1; fx = a; fy = b;
        step();
        move_valid = 1'b0;
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #1 reset = 1'b1;
        #1;
        check("rst_x", x3, 0);
        check("rst_y", y3, 0);
        check("rst_cnt", cnt3, 0);
        check("rst_rdy", rdy3, 0);
        check("rst_flags", {oob3, rch3, exh3}, 0);
        #1 reset = 1'b0;

        // Basic move onto target
        do_start(2, 3, 4, 3);
        check("s1_rdy", rdy3, 1);
        check("s1_x", x3, 2);
        check("s1_y", y3, 3);
        do_move(4, 3);
        check("m1_x", x3, 4);
        check("m1_cnt", cnt3, 1);
        check("m1_reached", rch3, 1);
        check("m1_rdy", rdy3, 0);

        // Borrow-wrapped move is out of bounds
        do_start(0, 5, 10, 10);
        check("s2_reached_clr", rch3, 0);
        check("s2_cnt", cnt3, 0);
        do_move(31, 5);
        check("m2_oob", oob3, 1);
        check("m2_x", x3, 0);
        check("m2_cnt", cnt3, 1);
        check("m2_settle_rdy", rdy3, 0);
        step();
        check("m2_oob_pulse", oob3, 0);
        check("m2_back_run", rdy3, 1);

        // Budget exhaustion (3 on u_dut3, 2 on u_dut2)
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        do_start(1, 1, 10, 10);
        do_move(2, 2);
        check("b1_cnt", cnt3, 1);
        step();
        do_move(3, 3);
        check("b2_cnt3", cnt3, 2);
        check("b2_exh3", exh3, 0);
        check("b2_exh2", exh2, 1);
        check("b2_x2", x2, 3);
        step();
        check("b2_rdy2", rdy2, 0);
        do_move(4, 4);
        check("b3_exh3", exh3, 1);
        check("b3_cnt3", cnt3, 3);
        check("b3_x3", x3, 4);
        check("b3_cnt2_frozen", cnt2, 2);
        move_valid = 1'b1; fx = 5; fy = 5;
        step();
        move_valid = 1'b0;
        check("b4_x3_ignored", x3, 4);
        check("b4_cnt3", cnt3, 3);
        check("b4_rdy3", rdy3, 0);

        // Target reached on the last budgeted move: DONE wins
        do_start(1, 1, 3, 3);
        check("t0_exh_clr", exh2, 0);
        do_move(2, 2);
        step();
        do_move(3, 3);
        check("t2_reached2", rch2, 1);
        check("t2_exh2", exh2, 0);
        check("t2_cnt2", cnt2, 2);
        check("t2_reached3", rch3, 1);

        // Reset during SETTLE
        do_start(1, 1, 10, 10);
        do_move(7, 7);
        check("r0_x", x3, 7);
        #1 reset = 1'b1;
        #1;
        check("r1_x", x3, 0);
        check("r1_y", y3, 0);
        check("r1_cnt", cnt3, 0);
        check("r1_flags", {rdy3, oob3, rch3, exh3}, 0);
        #1 reset = 1'b0;

        // Start at target, then illegal start
        do_start(9, 9, 9, 9);
        check("d_reached", rch3, 1);
        check("d_cnt", cnt3, 0);
        check("d_x", x3, 9);
        do_start(20, 1, 9, 9);
        check("f_oob", oob3, 1);
        check("f_x_kept", x3, 9);
        check("f_exh", exh3, 0);
        check("f_reached", rch3, 0);
        check("f_rdy", rdy3, 0);
        step();
        check("f_oob_pulse", oob3, 0);

        // Grid edge: 15 legal, 16 rejected
        do_start(3, 3, 9, 9);
        check("g_rdy", rdy3, 1);
        do_move(15, 15);
        check("g_x15", x3, 15);
        check("g_oob15", oob3, 0);
        step();
        do_move(16, 0);
        check("g_oob16", oob3, 1);
        check("g_x_kept", x3, 15);
        check("g_y_kept", y3, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/position_tracker.md
POSITION_TRACKER -- requirements
Module: position_tracker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter GRID_MAX, default 15: largest legal coordinate on either axis.
REQ-003 Parameter MAX_MOVES, default 31: move budget per run.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  async active-high reset.
REQ-006 start  input  1  load start position and begin a run.
REQ-007 sx, sy  input  5 each  start coordinates.
REQ-008 tx, ty  input  5 each  target coordinates, sampled every cycle.
REQ-009 move_valid  input  1  fx/fy hold a candidate move.
REQ-010 fx, fy  input  5 each  candidate coordinates from the coordinate-computation stage.
REQ-011 x, y  output  5 each  committed position, fed back to the coordinate stage.
REQ-012 move_ready  output  1  block accepts a move this cycle.
REQ-013 move_count  output  5  moves consumed this run.
REQ-014 oob  output  1  one-cycle pulse: last move rejected as out of bounds.
REQ-015 reached  output  1  level: target reached.
REQ-016 exhausted  output  1  level: budget spent without reaching target.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, SETTLE, DONE, FAIL.
REQ-018 A move SHALL be accepted only on a cycle where move_valid=1 and move_ready=1; move_ready SHALL be 1 only in RUN.
REQ-019 IDLE/DONE/FAIL, start=1: load x<=sx, y<=sy; clear move_count, reached, exhausted; go to RUN next cycle.
REQ-020 If sx>GRID_MAX or sy>GRID_MAX at start: go to FAIL; x/y keep their prior values; exhausted=0; oob pulses.
REQ-021 If (sx,sy)==(tx,ty) at start: go to DONE with move_count=0.
REQ-022 start SHALL be ignored in RUN and SETTLE.
REQ-023 Accepted move with fx<=GRID_MAX and fy<=GRID_MAX: commit x<=fx, y<=fy.
REQ-024 Accepted move with either coordinate above GRID_MAX: no commit, oob=1 for exactly one cycle. Borrow-wrapped values (e.g. 0-1=31) count as out of bounds.
REQ-025 Every accepted move, committed or rejected, SHALL increment move_count by 1.
REQ-026 After an accepted move the next state SHALL be:
 - DONE, if the committed position equals (tx,ty);
 - else FAIL, if the new move_count equals MAX_MOVES;
 - else SETTLE.
REQ-027 If the target is reached and the budget is exhausted on the same move, DONE SHALL win; reached=1, exhausted=0.
REQ-028 A rejected move SHALL never produce DONE.
REQ-029 SETTLE SHALL last exactly one cycle with move_ready=0, then return to RUN. This gives the upstream stage one cycle to re-register against the new x/y.
REQ-030 reached SHALL equal 1 exactly while in DONE; exhausted SHALL equal 1 exactly while in FAIL entered by budget.
REQ-031 All outputs SHALL be registered; latency from acceptance to updated x/y/move_count SHALL be one cycle.

Reset
REQ-032 Asserting reset SHALL immediately force: state IDLE, x=0, y=0, move_count=0, move_ready=0, oob=0, reached=0, exhausted=0.
REQ-033 Reset mid-run SHALL abandon the run; no partial commit SHALL survive.
REQ-034 Reset SHALL be released without a clock-edge requirement, and the first start SHALL be honoured on the first edge after release.

Structure
REQ-035 Shared package coord_pkg SHALL hold COORD_W=5, GRID_MAX, MAX_MOVES and the state encoding.
REQ-036 One combinational sub-module, in_bounds, SHALL compare a coordinate pair against GRID_MAX; it SHALL be used for both start and move checks.

Verification
REQ-037 Reset, then start with (sx,sy)=(2,3), target (4,3); move fx=4,fy=3 -> x=4, move_count=1, reached=1 one cycle after acceptance.
REQ-038 At (0,5), move fx=31,fy=5 -> oob pulses for 1 cycle, x stays 0, move_count increments, next state SETTLE.
REQ-039 MAX_MOVES=3, target never hit, 3 legal moves -> exhausted=1 after the third; further move_valid ignored (move_ready=0).
REQ-040 MAX_MOVES=2, second move lands on target -> reached=1, exhausted=0.
REQ-041 Assert reset during SETTLE after a commit to (7,7) -> x=y=0, IDLE, all flags 0 without a clock edge.
REQ-042 Start with (sx,sy)=(9,9)=(tx,ty) -> DONE next cycle, move_count=0; start with sx=20 -> FAIL, oob pulse.
